modulator_cmd_frontend: RTL

- Upstream stage of the modulator/PWM system; converts raw board inputs (push button plus switches) into a clean command for the digital modulator.
- Synchronises and debounces the send button and latches message, mode and cnt.
- Issues exactly one single-cycle send pulse per button press, then locks out further presses so a transmission in progress is not disturbed.

---
 rtl/modulator_pkg.sv | 16 +
 rtl/level_debouncer.sv | 52 +++++
 rtl/modulator_cmd_frontend.sv | 135 +++++++++++++
 3 files changed

// File: rtl/modulator_pkg.sv
// Shared definitions for the modulator command path: front-end FSM states
// and the default message/cnt widths used by the front end and the modulator.
package modulator_pkg;

  localparam int MSG_W_DEF = 5;
  localparam int CNT_W_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_PRESS_QUAL = 3'd1,
    ST_ISSUE      = 3'd2,
    ST_LOCKOUT    = 3'd3,
    ST_REL_QUAL   = 3'd4
  } fe_state_e;

endpackage

// File: rtl/level_debouncer.sv
// Two-flop synchroniser plus a stable-count qualifier. The owner chooses the
// level to qualify (target) and may hold the count at zero (restart);
// stable_level is high on the cycle in which btn_s has matched target for
// DEBOUNCE_CYCLES consecutive cycles.
module level_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  input  logic target,
  input  logic restart,
  output logic btn_s,
  output logic stable_level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SAT  = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("level_debouncer: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] dcnt_q, dcnt_d;

  assign btn_s        = sync_q[1];
  assign stable_level = (btn_s == target) && (dcnt_q == CNT_LAST);

  // Next-state: shift the synchroniser and run the saturating stable counter.
  always_comb begin
    sync_d = {sync_q[0], din};
    dcnt_d = '0;
    if (!restart && (btn_s == target)) begin
      dcnt_d = (dcnt_q == CNT_SAT) ? dcnt_q : dcnt_q + CNT_ONE;
    end
  end

  // Register synchroniser and counter; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      dcnt_q <= '0;
    end else begin
      sync_q <= sync_d;
      dcnt_q <= dcnt_d;
    end
  end

endmodule

// File: rtl/modulator_cmd_frontend.sv
// Board-input front end for the modulator: debounces the send button, issues
// one send pulse per press with the switch settings latched on the same edge,
// then holds busy through a lockout and waits for a clean release.
module modulator_cmd_frontend
  import modulator_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LOCKOUT_CYCLES  = 2048,
  parameter int MSG_W           = MSG_W_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             send_btn,
  input  logic             mode_sw,
  input  logic [MSG_W-1:0] message_sw,
  input  logic [CNT_W-1:0] cnt_sw,
  output logic             send,
  output logic             mode,
  output logic [MSG_W-1:0] message,
  output logic [CNT_W-1:0] cnt,
  output logic             busy
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
  localparam logic [LW-1:0] LOCK_LAST = LW'(LOCKOUT_CYCLES - 1);
  localparam logic [LW-1:0] LOCK_ONE  = LW'(1);

  if (LOCKOUT_CYCLES < 1) begin : g_bad_lockout
    $error("modulator_cmd_frontend: LOCKOUT_CYCLES must be >= 1");
  end

  fe_state_e        state_q, state_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             send_q, send_d;
  logic             busy_q, busy_d;
  logic             mode_q, mode_d;
  logic [MSG_W-1:0] message_q, message_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic btn_s;
  logic qualified;
  logic qual_target;
  logic qual_restart;

  level_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk         (clk),
    .rst         (rst),
    .din         (send_btn),
    .target      (qual_target),
    .restart     (qual_restart),
    .btn_s       (btn_s),
    .stable_level(qualified)
  );

  // FSM next-state; send/busy are decoded from the next state so they are
  // registered and line up with the latched switch values.
  always_comb begin
    state_d      = state_q;
    lock_d       = '0;
    send_d       = 1'b0;
    busy_d       = 1'b0;
    mode_d       = mode_q;
    message_d    = message_q;
    cnt_d        = cnt_q;
    qual_target  = 1'b1;
    qual_restart = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (btn_s) state_d = ST_PRESS_QUAL;
      end
      ST_PRESS_QUAL: begin
        qual_restart = 1'b0;
        if (!btn_s) begin
          state_d = ST_IDLE;
        end else if (qualified) begin
          state_d   = ST_ISSUE;
          send_d    = 1'b1;
          busy_d    = 1'b1;
          mode_d    = mode_sw;
          message_d = message_sw;
          cnt_d     = cnt_sw;
        end
      end
      ST_ISSUE: begin
        state_d = ST_LOCKOUT;
        busy_d  = 1'b1;
      end
      ST_LOCKOUT: begin
        if (lock_q == LOCK_LAST) begin
          state_d = ST_REL_QUAL;
        end else begin
          lock_d = lock_q + LOCK_ONE;
          busy_d = 1'b1;
        end
      end
      ST_REL_QUAL: begin
        qual_restart = 1'b0;
        qual_target  = 1'b0;
        if (qualified) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter and output registers; reset clears everything at once.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      lock_q    <= '0;
      send_q    <= 1'b0;
      busy_q    <= 1'b0;
      mode_q    <= 1'b0;
      message_q <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      lock_q    <= lock_d;
      send_q    <= send_d;
      busy_q    <= busy_d;
      mode_q    <= mode_d;
      message_q <= message_d;
      cnt_q     <= cnt_d;
    end
  end

  assign send    = send_q;
  assign busy    = busy_q;
  assign mode    = mode_q;
  assign message = message_q;
  assign cnt     = cnt_q;

endmodule
